// File: rtl/csa_acc_pkg.sv
// rtl/csa_acc_pkg.sv - shared state encoding and resolve bound for csa_accumulator
package csa_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int DEFAULT_ACC_W = 8;

  // Carry-propagate loop bound: each iteration pushes the lowest set carry bit up one place.
  localparam int MAX_RESOLVE_ITERS = DEFAULT_ACC_W + 1;

  function automatic int max_resolve_iters(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/csa.sv
// rtl/csa.sv - W-bit 3:2 carry-save compressor; carry is the unshifted majority vector
module csa #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - streaming multi-operand adder with carry-save accumulation
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t             state;
  logic [ACC_W-1:0]   s_q;
  logic [ACC_W-1:0]   c_q;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   x;
  logic [ACC_W-1:0]   csa_sum;
  logic [ACC_W-1:0]   csa_maj;
  logic [ACC_W-1:0]   rs_and;

  assign x      = ACC_W'(in_data);
  assign rs_and = s_q & c_q;

  csa #(.W(ACC_W)) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (x),
    .sum   (csa_sum),
    .carry (csa_maj)
  );

  assign in_ready = (state == ACCUM);

  // Carry bits shifted out of the MSB are folded into ovf so the overflow flag stays exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
            s_q   <= csa_sum;
            c_q   <= csa_maj << 1;
            ovf_q <= ovf_q | csa_maj[ACC_W-1];
            if (count_q != '1) begin
              count_q <= count_q + 1'b1;
            end
            if (in_last) begin
              state <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          if (c_q == '0) begin
            out_sum   <= s_q;
            out_count <= count_q;
            out_ovf   <= ovf_q;
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            s_q   <= s_q ^ c_q;
            c_q   <= rs_and << 1;
            ovf_q <= ovf_q | rs_and[ACC_W-1];
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - scoreboard bench for csa_accumulator
module tb_csa_accumulator;

  localparam int N     = 4;
  localparam int ACC_W = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  logic out_ready_dir;
  logic bp_bit;
  logic bp_mode;

  assign out_ready = bp_mode ? bp_bit : out_ready_dir;

  csa_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cnt;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    bp_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: every accepted result is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("in_ready_low_while_valid", 32'(in_ready), 32'd0);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_sum", 32'(out_sum), 32'(mon_e.sum));
          check("out_count", 32'(out_count), 32'(mon_e.cnt));
          check("out_ovf", 32'(out_ovf), 32'(mon_e.ovf));
        end
      end
    end
  end

  task automatic send_beat(input int v, input bit last, input int gap_max);
    int g;
    int t;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    repeat (g) begin
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      in_data  = N'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = N'(v);
    in_last  = last;
    t = 0;
    while (!in_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check("in_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference model: plain integer total of the packet.
  task automatic send_packet(input int vals[$], input int gap_max);
    exp_t e;
    int   total;
    total = 0;
    foreach (vals[i]) total += vals[i];
    e.sum = total % (1 << ACC_W);
    e.cnt = (vals.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : vals.size();
    e.ovf = (total >= (1 << ACC_W)) ? 1 : 0;
    exp_q.push_back(e);
    foreach (vals[i]) send_beat(vals[i], i == vals.size() - 1, gap_max);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic expect_latency(input int edges);
    for (int i = 1; i <= edges; i++) begin
      @(posedge clk); #1;
      check("latency_out_valid", 32'(out_valid), (i == edges) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int q[$];
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_data       = '0;
    in_last       = 1'b0;
    out_ready_dir = 1'b1;
    bp_mode       = 1'b0;
    bp_bit        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    q = {10, 12, 6};
    send_packet(q, 0);
    wait_drain();

    q = {15, 15};
    send_packet(q, 0);
    check("latency_at_accept", 32'(out_valid), 32'd0);
    expect_latency(2);
    wait_drain();

    q = {};
    repeat (20) q.push_back(15);
    send_packet(q, 0);
    wait_drain();

    out_ready_dir = 1'b0;
    q = {9};
    send_packet(q, 0);
    expect_latency(1);
    repeat (5) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sum", 32'(out_sum), 32'd9);
      check("stall_out_count", 32'(out_count), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready_dir = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    wait_drain();

    q = {1, 2, 3, 4};
    send_packet(q, 4);
    wait_drain();

    send_beat(15, 1'b0, 0);
    send_beat(15, 1'b1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_sum", 32'(out_sum), 32'd0);
    check("abort_out_count", 32'(out_count), 32'd0);
    check("abort_out_ovf", 32'(out_ovf), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q = {5};
    send_packet(q, 0);
    wait_drain();

    bp_mode = 1'b1;
    q = {};
    repeat (300) q.push_back($urandom_range(0, 15));
    send_packet(q, 0);
    wait_drain();

    for (int p = 0; p < 25; p++) begin
      q = {};
      repeat ($urandom_range(1, 12)) q.push_back($urandom_range(0, 15));
      send_packet(q, 3);
    end
    wait_drain();
    bp_mode = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
